// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and constants for the memory-stage access engine.
package mem_pkg;
    localparam int WB_CTRL_W          = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts enabled cycles; expired flags the LIMIT-th consecutive enabled cycle.
module mem_timeout_ctr
    import mem_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    assign expired = enable && (count == W'(LIMIT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine feeding MEM/WB over a req/ack memory port.
// Define MEM_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT_CYCLES.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [WB_CTRL_W-1:0] wb_ctrl_in,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    store_data,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 wb_valid,
    output logic [WB_CTRL_W-1:0] wb_ctrl,
    output logic [DATA_W-1:0]    result_out,
    output logic [DATA_W-1:0]    read_data_out,
    output logic                 mem_err
);
    state_t state, next;
    logic mem_op, timeout, finish;
    logic [WB_CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] result_q;

    assign mem_op = ex_valid & (mem_read | mem_write);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .rst(rst),
        .clear(state != ACCESS),
        .enable(state == ACCESS),
        .expired(timeout)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            mem_err <= 1'b0;
        else
            mem_err <= (state == ACCESS) && !dmem_ack && timeout;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // an ack in the same cycle as expiry completes the access normally
    assign finish = (state == ACCESS) && (dmem_ack || timeout);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= next;

    always_comb
        next = (state == IDLE)   ? (mem_op ? ACCESS : IDLE) :
               (state == ACCESS) ? (finish ? DONE : ACCESS) : IDLE;

    // gated by reset so upstream is released the moment reset asserts
    always_comb
        stall = rst & (((state == IDLE) & mem_op) | (state == ACCESS));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_ctrl       <= '0;
            result_out    <= '0;
            read_data_out <= '0;
            ctrl_q        <= '0;
            result_q      <= '0;
        end else begin
            case (state)
                IDLE:
                    if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= alu_result;
                        dmem_wdata <= store_data;
                        ctrl_q     <= wb_ctrl_in;
                        result_q   <= alu_result;
                        wb_valid   <= 1'b0;
                    end else begin
                        wb_valid      <= ex_valid;
                        wb_ctrl       <= wb_ctrl_in;
                        result_out    <= alu_result;
                        read_data_out <= '0;
                    end
                ACCESS:
                    if (finish) begin
                        dmem_req      <= 1'b0;
                        read_data_out <= (dmem_ack && !dmem_we) ? dmem_rdata : '0;
                        result_out    <= result_q;
                        wb_ctrl       <= ctrl_q;
                        wb_valid      <= 1'b1;
                    end
                default:
                    wb_valid <= 1'b0;
            endcase
        end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a responsive memory model and randomized instruction stream.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_read, mem_write;
    logic [1:0]  wb_ctrl_in;
    logic [31:0] alu_result, store_data;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, mem_err;
    logic [1:0]  wb_ctrl;
    logic [31:0] result_out, read_data_out;

    mem_access_unit #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_ctrl_in(wb_ctrl_in), .alu_result(alu_result), .store_data(store_data), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
        .result_out(result_out), .read_data_out(read_data_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] c; logic [31:0] r; logic [31:0] d; } wb_t;
    typedef struct { logic we; logic [31:0] a; logic [31:0] d; } req_t;
    wb_t  sb[$];
    req_t mq[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0, passed = 0, errs = 0, exp_errs = 0;
    int force_delay = -1, last_delay = 0;
    bit mute = 0, spurious_en = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
    endfunction

    // memory model: checks each request, acks after a chosen wait, sprays ignored acks when idle
    initial begin
        req_t cur;
        int wait_n;
        bit busy;
        busy = 0; wait_n = 0; dmem_ack = 1'b0; dmem_rdata = '0;
        cur = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (!rst || !dmem_req) begin
                busy = 0;
                if (rst && spurious_en && $urandom_range(0, 3) == 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = $urandom;
                end
            end else begin
                if (!busy) begin
                    busy = 1;
                    if (mq.size() == 0) chk("unexpected_req", 32'(dmem_req), 32'h0);
                    else begin
                        cur = mq.pop_front();
                        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                        chk("dmem_addr", dmem_addr, cur.a);
                        chk("dmem_wdata", dmem_wdata, cur.d);
                    end
                    wait_n = force_delay >= 0 ? force_delay : int'($urandom_range(0, 3));
                    last_delay = wait_n;
                end else
                    chk("req_hold", 32'({dmem_we, dmem_addr, dmem_wdata} == {cur.we, cur.a, cur.d}), 32'h1);
                if (!mute) begin
                    if (wait_n == 0) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = mem_val(dmem_addr);
                    end else
                        wait_n--;
                end
            end
        end
    end

    // monitor: every wb_valid cycle must match the oldest outstanding instruction
    initial forever begin
        wb_t e;
        @(negedge clk);
        if (rst && mem_err) errs++;
        if (rst && wb_valid) begin
            if (sb.size() == 0) chk("unexpected_wb", 32'(wb_valid), 32'h0);
            else begin
                e = sb.pop_front();
                chk("wb_ctrl", 32'(wb_ctrl), 32'(e.c));
                chk("result_out", result_out, e.r);
                chk("read_data_out", read_data_out, e.d);
            end
        end
    end

    task automatic issue(input logic v, input logic rd, input logic wr, input logic [1:0] c,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        logic op;
        op = v & (rd | wr);
        ex_valid = v; mem_read = rd; mem_write = wr; wb_ctrl_in = c; alu_result = a; store_data = d;
        if (v) sb.push_back('{c, a, (op && rd && !wr && !mute) ? mem_val(a) : 32'h0});
        if (op) mq.push_back('{wr, a, d});
        n = 0;
        #1;
        while (stall && n < 64) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", n, op ? (mute ? TO + 1 : last_delay + 2) : 0);
        if (!op) begin
            @(negedge clk);
            #1;
        end
        chk("wb_timing", 32'(wb_valid), 32'(v));
        if (op) begin
            @(negedge clk);
            #1;
        end
        ex_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        wb_ctrl_in = 2'b11; alu_result = 32'hDEAD_BEEF; store_data = 32'h1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_outputs", 32'({dmem_req, dmem_we, wb_valid, mem_err}), 32'h0);
        chk("rst_data", dmem_addr | dmem_wdata | result_out | read_data_out | 32'(wb_ctrl), 32'h0);
        repeat (2) @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;

        // asynchronous reset in the middle of an access
        mute = 1;
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h100; store_data = '0;
        mq.push_back('{1'b0, 32'h100, 32'h0});
        @(negedge clk);
        #1;
        chk("midrst_req_before", 32'(dmem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_wb_valid", 32'(wb_valid), 32'h0);
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mute = 0;
        @(negedge clk);
        #1;

        issue(1, 0, 0, 2'b10, 32'h0000_0010, 32'h0);
        mem[32'h40] = 32'hCAFE_F00D;
        force_delay = 2;
        issue(1, 1, 0, 2'b01, 32'h40, 32'h0);
        force_delay = 0;
        issue(1, 0, 1, 2'b00, 32'h80, 32'h1234);
        spurious_en = 1;
        mem[32'h44] = 32'h0BAD_F00D;
        issue(1, 1, 0, 2'b01, 32'h40, 32'h0);
        issue(1, 1, 0, 2'b11, 32'h44, 32'h0);
        issue(1, 1, 1, 2'b10, 32'h48, 32'h5555_AAAA);
        force_delay = -1;

`ifdef MEM_TIMEOUT_EN
        mute = 1;
        exp_errs++;
        issue(1, 1, 0, 2'b01, 32'h200, 32'h0);
        mute = 0;
`endif

        for (int i = 0; i < 300; i++) begin
            logic v, rd, wr;
            int t;
            v = $urandom_range(0, 5) != 0;
            t = $urandom_range(0, 3);
            rd = (t == 1) || (t == 3);
            wr = (t == 2) || (t == 3);
            issue(v, rd, wr, 2'($urandom), $urandom, $urandom);
        end

        spurious_en = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("mq_drained", mq.size(), 0);
        chk("mem_err_total", errs, exp_errs);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
